// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the CPU/DMA memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_CPU) ? OWN_DMA : OWN_CPU;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU datapath and a DMA requester.
// Each grant holds the port for MEM_LAT cycles, then returns a one-cycle ack with read data.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  arb_state_t        r_state, w_state_nxt;
  owner_t            r_ptr, w_ptr_nxt;
  owner_t            r_owner, w_owner_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_we_l, w_we_nxt;
  logic [ADDR_W-1:0] r_addr_l, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata_l, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_cpu_ack, w_cpu_ack_nxt;
  logic              r_dma_ack, w_dma_ack_nxt;
  logic              r_mem_read, w_mem_read_nxt;
  logic              r_mem_write, w_mem_write_nxt;

  logic              w_any_req;
  logic              w_pick_dma;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  // DMA wins only when it is alone or when the pointer favours it.
  assign w_any_req   = cpu_req | dma_req;
  assign w_pick_dma  = dma_req & (~cpu_req | (r_ptr == OWN_DMA));
  assign w_sel_we    = w_pick_dma ? dma_we    : cpu_we;
  assign w_sel_addr  = w_pick_dma ? dma_addr  : cpu_addr;
  assign w_sel_wdata = w_pick_dma ? dma_wdata : cpu_wdata;

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we_l;
    w_addr_nxt      = r_addr_l;
    w_wdata_nxt     = r_wdata_l;
    w_rdata_nxt     = r_rdata;
    w_busy_nxt      = r_busy;
    w_cpu_ack_nxt   = 1'b0;
    w_dma_ack_nxt   = 1'b0;
    w_mem_read_nxt  = 1'b0;
    w_mem_write_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt     = BUSY;
          w_owner_nxt     = w_pick_dma ? OWN_DMA : OWN_CPU;
          w_we_nxt        = w_sel_we;
          w_addr_nxt      = w_sel_addr;
          w_wdata_nxt     = w_sel_wdata;
          w_cnt_nxt       = '0;
          w_busy_nxt      = 1'b1;
          w_mem_read_nxt  = ~w_sel_we;
          w_mem_write_nxt = w_sel_we;
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_nxt   = DONE;
          w_cpu_ack_nxt = (r_owner == OWN_CPU);
          w_dma_ack_nxt = (r_owner == OWN_DMA);
          if (!r_we_l) begin
            w_rdata_nxt = mem_rdata;
          end
        end else begin
          w_mem_read_nxt  = ~r_we_l;
          w_mem_write_nxt = r_we_l;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = other_owner(r_owner);
      end
      default: begin
        w_state_nxt = IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= OWN_CPU;
      r_owner     <= OWN_CPU;
      r_cnt       <= '0;
      r_we_l      <= 1'b0;
      r_addr_l    <= '0;
      r_wdata_l   <= '0;
      r_rdata     <= '0;
      r_busy      <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we_l      <= w_we_nxt;
      r_addr_l    <= w_addr_nxt;
      r_wdata_l   <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_busy      <= w_busy_nxt;
      r_cpu_ack   <= w_cpu_ack_nxt;
      r_dma_ack   <= w_dma_ack_nxt;
      r_mem_read  <= w_mem_read_nxt;
      r_mem_write <= w_mem_write_nxt;
    end
  end

  assign cpu_ack   = r_cpu_ack;
  assign dma_ack   = r_dma_ack;
  assign cpu_stall = cpu_req & ~r_cpu_ack;
  assign rdata     = r_rdata;
  assign owner     = r_owner;
  assign busy      = r_busy;
  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_addr_l;
  assign mem_wdata = r_wdata_l;

  a_single_ack: assert property (@(posedge clk) disable iff (rst) !(r_cpu_ack && r_dma_ack));
  a_single_strobe: assert property (@(posedge clk) disable iff (rst) !(r_mem_read && r_mem_write));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter at MEM_LAT = 1 and 3, checked cycle by cycle against a
// transaction-level scheduler model (grant time, owner, shadow memory).
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // [instance][requester]: requester 0 = CPU, 1 = DMA
  logic        req   [2][2];
  logic        we    [2][2];
  logic [11:0] addr  [2][2];
  logic [11:0] wd    [2][2];
  logic        ack   [2][2];
  logic        stall [2];
  logic [11:0] rdata [2];
  logic        owner [2];
  logic        busy  [2];
  logic        m_rd  [2];
  logic        m_wr  [2];
  logic [11:0] maddr [2];
  logic [11:0] mwd   [2];
  logic [11:0] mrd   [2];

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .cpu_req(req[0][0]), .cpu_we(we[0][0]), .cpu_addr(addr[0][0]), .cpu_wdata(wd[0][0]),
    .cpu_ack(ack[0][0]), .cpu_stall(stall[0]),
    .dma_req(req[0][1]), .dma_we(we[0][1]), .dma_addr(addr[0][1]), .dma_wdata(wd[0][1]),
    .dma_ack(ack[0][1]), .rdata(rdata[0]), .owner(owner[0]), .busy(busy[0]),
    .mem_read(m_rd[0]), .mem_write(m_wr[0]), .mem_addr(maddr[0]), .mem_wdata(mwd[0]),
    .mem_rdata(mrd[0])
  );

  mem_port_arbiter #(.ADDR_W(12), .DATA_W(12), .MEM_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .cpu_req(req[1][0]), .cpu_we(we[1][0]), .cpu_addr(addr[1][0]), .cpu_wdata(wd[1][0]),
    .cpu_ack(ack[1][0]), .cpu_stall(stall[1]),
    .dma_req(req[1][1]), .dma_we(we[1][1]), .dma_addr(addr[1][1]), .dma_wdata(wd[1][1]),
    .dma_ack(ack[1][1]), .rdata(rdata[1]), .owner(owner[1]), .busy(busy[1]),
    .mem_read(m_rd[1]), .mem_write(m_wr[1]), .mem_addr(maddr[1]), .mem_wdata(mwd[1]),
    .mem_rdata(mrd[1])
  );

  int n_vec = 0;
  int n_err = 0;

  // Model: cyc counts non-reset clock edges; a grant at edge g occupies g..g+lat-1 (BUSY)
  // and g+lat (ack), and the next grant may happen at edge g+lat+2 at the earliest.
  int          cyc = 0;
  bit          has   [2];
  int          g     [2];
  int          x_own [2];
  bit          x_we  [2];
  logic [11:0] x_addr[2];
  logic [11:0] x_wd  [2];
  logic [11:0] x_rd  [2];
  logic [11:0] e_rdata[2];
  int          e_own [2];
  int          ptr   [2];
  logic [11:0] shadow [2][4096];

  task automatic chk(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[lat%0d] @cyc %0d: got 0x%0h, expected 0x%0h", tag, (i == 0) ? 1 : 3, cyc, got, exp);
    end
  endtask

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic bit m_busy(input int i);
    return has[i] && (cyc >= g[i]) && (cyc <= g[i] + lat(i) - 1);
  endfunction

  function automatic bit m_done(input int i);
    return has[i] && (cyc == g[i] + lat(i));
  endfunction

  function automatic bit m_last(input int i);
    return has[i] && (cyc == g[i] + lat(i) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      has[i]     = 1'b0;
      ptr[i]     = 0;
      e_own[i]   = 0;
      e_rdata[i] = 12'h000;
    end
  endtask

  task automatic model_update();
    int w;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (m_done(i) && !x_we[i]) e_rdata[i] = x_rd[i];
      if ((!has[i] || cyc >= g[i] + lat(i) + 2) && (req[i][0] || req[i][1])) begin
        w = (req[i][0] && req[i][1]) ? ptr[i] : (req[i][1] ? 1 : 0);
        has[i]    = 1'b1;
        g[i]      = cyc;
        x_own[i]  = w;
        e_own[i]  = w;
        x_we[i]   = we[i][w];
        x_addr[i] = addr[i][w];
        x_wd[i]   = wd[i][w];
        if (x_we[i]) shadow[i][x_addr[i]] = x_wd[i];
        else         x_rd[i] = shadow[i][x_addr[i]];
        ptr[i] = 1 - w;
      end
    end
  endtask

  task automatic check_all();
    bit done_c;
    for (int i = 0; i < 2; i++) begin
      done_c = m_done(i) && (x_own[i] == 0);
      chk("cpu_ack",   i, 32'(ack[i][0]), 32'(done_c));
      chk("dma_ack",   i, 32'(ack[i][1]), 32'(m_done(i) && (x_own[i] == 1)));
      chk("cpu_stall", i, 32'(stall[i]),  32'(req[i][0] && !done_c));
      chk("mem_read",  i, 32'(m_rd[i]),   32'(m_busy(i) && !x_we[i]));
      chk("mem_write", i, 32'(m_wr[i]),   32'(m_busy(i) && x_we[i]));
      chk("busy",      i, 32'(busy[i]),   32'(m_busy(i) || m_done(i)));
      chk("owner",     i, 32'(owner[i]),  32'(e_own[i]));
      chk("rdata",     i, 32'(rdata[i]),  32'(e_rdata[i]));
      if (m_busy(i)) begin
        chk("mem_addr", i, 32'(maddr[i]), 32'(x_addr[i]));
        if (x_we[i]) chk("mem_wdata", i, 32'(mwd[i]), 32'(x_wd[i]));
      end
    end
  endtask

  // One clock: model and checks at the falling edge, memory data valid only in the
  // last BUSY cycle of a read, then inputs may be changed 1 time unit later.
  task automatic step();
    @(negedge clk);
    if (!rst) begin
      model_update();
      check_all();
    end
    for (int i = 0; i < 2; i++)
      mrd[i] = (!rst && m_last(i) && !x_we[i]) ? x_rd[i] : 12'($urandom);
    #1;
  endtask

  task automatic chk_zero(input int i);
    chk("rst_cpu_ack",   i, 32'(ack[i][0]), 32'd0);
    chk("rst_dma_ack",   i, 32'(ack[i][1]), 32'd0);
    chk("rst_rdata",     i, 32'(rdata[i]),  32'd0);
    chk("rst_busy",      i, 32'(busy[i]),   32'd0);
    chk("rst_owner",     i, 32'(owner[i]),  32'd0);
    chk("rst_mem_read",  i, 32'(m_rd[i]),   32'd0);
    chk("rst_mem_write", i, 32'(m_wr[i]),   32'd0);
    chk("rst_mem_addr",  i, 32'(maddr[i]),  32'd0);
    chk("rst_mem_wdata", i, 32'(mwd[i]),    32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    step();
  endtask

  task automatic xfer(input int i, input int j, input bit w, input logic [11:0] a,
                      input logic [11:0] d, output logic [11:0] rd);
    int c0, ns;
    bit got;
    req[i][j] = 1'b1; we[i][j] = w; addr[i][j] = a; wd[i][j] = d;
    c0 = cyc; ns = 0; got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      step();
      if (m_rd[i] || m_wr[i]) ns++;
      got = ack[i][j];
    end
    chk("xfer_ack_seen", i, 32'(got), 32'd1);
    chk("xfer_latency",  i, 32'(cyc - c0), 32'(lat(i) + 1));
    chk("strobe_cycles", i, 32'(ns), 32'(lat(i)));
    rd = rdata[i];
    req[i][j] = 1'b0;
    step();
  endtask

  task automatic wait_ack(input int i, output int who);
    who = -1;
    for (int k = 0; k < 20 && who < 0; k++) begin
      step();
      if (ack[i][0])      who = 0;
      else if (ack[i][1]) who = 1;
    end
    if (who < 0) chk("ack_timeout", i, 32'd0, 32'd1);
  endtask

  task automatic new_ops(input int i, input int j);
    we[i][j]   = 1'($urandom_range(0, 1));
    addr[i][j] = 12'($urandom_range(0, 31));
    wd[i][j]   = 12'($urandom);
  endtask

  task automatic agent(input int i, input int j);
    bit mine_done, mine_busy;
    mine_done = m_done(i) && (x_own[i] == j);
    mine_busy = m_busy(i) && (x_own[i] == j);
    if (req[i][j]) begin
      if (mine_done) begin
        if ($urandom_range(0, 1) == 1) new_ops(i, j);
        else req[i][j] = 1'b0;
      end else if (mine_busy) begin
        new_ops(i, j);
        if ($urandom_range(0, 15) == 0) req[i][j] = 1'b0;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      req[i][j] = 1'b1;
      new_ops(i, j);
    end
  endtask

  initial begin
    logic [11:0] rd;
    int who;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mrd[i] = 12'h000;
      for (int j = 0; j < 2; j++) begin
        req[i][j] = 1'b0; we[i][j] = 1'b0; addr[i][j] = 12'h000; wd[i][j] = 12'h000;
      end
      for (int a = 0; a < 4096; a++) shadow[i][a] = 12'($urandom);
    end
    shadow[0][12'h07F] = 12'h5A3;
    shadow[1][12'h2C4] = 12'h3E1;
    model_reset();
    repeat (3) step();
    chk_zero(0);
    chk_zero(1);
    rst = 1'b0;
    step();

    // Single CPU read, then DMA write followed by CPU read-back, at MEM_LAT = 1.
    xfer(0, 0, 1'b0, 12'h07F, 12'h000, rd);
    chk("cpu_read_07f", 0, 32'(rd), 32'h5A3);
    xfer(0, 1, 1'b1, 12'h100, 12'hABC, rd);
    xfer(0, 0, 1'b0, 12'h100, 12'h000, rd);
    chk("readback_100", 0, 32'(rd), 32'hABC);

    // MEM_LAT = 3 read: three strobe cycles, ack four cycles after the request edge.
    xfer(1, 0, 1'b0, 12'h2C4, 12'h000, rd);
    chk("lat3_read", 1, 32'(rd), 32'h3E1);

    // Both held continuously after a fresh reset: CPU, DMA, CPU, DMA.
    do_reset();
    req[0][0] = 1'b1; we[0][0] = 1'b0; addr[0][0] = 12'h005;
    req[0][1] = 1'b1; we[0][1] = 1'b1; addr[0][1] = 12'h006; wd[0][1] = 12'h123;
    for (int k = 0; k < 4; k++) begin
      wait_ack(0, who);
      chk("alternate_owner", 0, 32'(who), 32'(k % 2));
    end
    req[0][0] = 1'b0; req[0][1] = 1'b0;
    step();

    // DMA arrives during a CPU BUSY; CPU re-requests right after its ack but DMA goes next.
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 12'h007;
    step();
    step();
    req[1][1] = 1'b1; we[1][1] = 1'b1; addr[1][1] = 12'h008; wd[1][1] = 12'h456;
    wait_ack(1, who);
    chk("waiting_first_cpu", 1, 32'(who), 32'd0);
    wait_ack(1, who);
    chk("waiting_dma_next", 1, 32'(who), 32'd1);
    req[1][1] = 1'b0;
    wait_ack(1, who);
    chk("cpu_after_dma", 1, 32'(who), 32'd0);
    req[1][0] = 1'b0;
    step();

    // Reset in the second BUSY cycle of a CPU read at MEM_LAT = 3.
    req[1][0] = 1'b1; we[1][0] = 1'b0; addr[1][0] = 12'h009;
    step();
    step();
    chk("busy_before_rst", 1, 32'(busy[1]), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_read", 1, 32'(m_rd[1]),   32'd0);
    chk("rst_mid_busy",     1, 32'(busy[1]),   32'd0);
    chk("rst_mid_cpu_ack",  1, 32'(ack[1][0]), 32'd0);
    model_reset();
    req[1][1] = 1'b1; we[1][1] = 1'b0; addr[1][1] = 12'h00A;
    step();
    step();
    rst = 1'b0;
    wait_ack(1, who);
    chk("post_rst_winner", 1, 32'(who), 32'd0);
    req[1][0] = 1'b0; req[1][1] = 1'b0;
    step();
    step();

    // Random traffic on both instances.
    repeat (3000) begin
      step();
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          agent(i, j);
    end
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        req[i][j] = 1'b0;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
